time_setter: RTL

- Front-panel time-editing block for the digital clock.
- Takes three raw push-buttons (mode, up, down), debounces them, and walks an edit FSM through hours, minutes and seconds.
- Drives the modified_hours/minutes/seconds bus and a per-digit blink mask that the display scanner consumes.
- Emits a one-cycle commit strobe so the timekeeping core can load the edited time.

---
 rtl/time_setter_pkg.sv | 32 +++
 rtl/time_setter_if.sv | 26 ++
 rtl/time_setter_btn_debounce.sv | 36 +++
 rtl/time_setter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/time_setter_pkg.sv
// rtl/time_setter_pkg.sv - shared state encoding, field limits and blink bit masks for time_setter
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  localparam logic [5:0] BLINK_SEC  = 6'b000011;
  localparam logic [5:0] BLINK_MIN  = 6'b001100;
  localparam logic [5:0] BLINK_HOUR = 6'b110000;

  // Wrapping +/-1 step; an out-of-range start value snaps to 0.
  function automatic logic [5:0] step_field(input logic [5:0] value,
                                            input logic [5:0] max_val,
                                            input logic       up);
    logic [5:0] result;
    if (value > max_val)
      result = 6'd0;
    else if (up)
      result = (value == max_val) ? 6'd0 : value + 6'd1;
    else
      result = (value == 6'd0) ? max_val : value - 6'd1;
    return result;
  endfunction

endpackage

// File: rtl/time_setter_if.sv
// rtl/time_setter_if.sv - front-panel buttons, running time and edited-time display bus
interface time_setter_if;
  logic       enable;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [5:0] modified_hours;
  logic [5:0] modified_minutes;
  logic [5:0] modified_seconds;
  logic [5:0] blink_mask;
  logic       set_active;
  logic       commit;

  modport master (
    output enable, btn_mode, btn_up, btn_down, cur_hours, cur_minutes, cur_seconds,
    input  modified_hours, modified_minutes, modified_seconds, blink_mask, set_active, commit
  );

  modport slave (
    input  enable, btn_mode, btn_up, btn_down, cur_hours, cur_minutes, cur_seconds,
    output modified_hours, modified_minutes, modified_seconds, blink_mask, set_active, commit
  );
endinterface

// File: rtl/time_setter_btn_debounce.sv
// rtl/time_setter_btn_debounce.sv - 2-flop synchronizer, stable-count debouncer and rise pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/time_setter.sv
// rtl/time_setter.sv - debounced hh:mm:ss edit FSM with blink mask and commit strobe
// Optional hold-to-repeat on up/down: TIME_SETTER_AUTO_REPEAT_EN.
module time_setter
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 2_000_000,
  parameter int BLINK_CYCLES        = 25_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  time_setter_if.slave  ts
);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic lvl_mode, lvl_up, lvl_down;
  logic prs_mode, prs_up, prs_down;
  logic rep_up, rep_down;
  logic unused_repeat;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn(ts.btn_mode), .level(lvl_mode), .press(prs_mode));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn(ts.btn_up), .level(lvl_up), .press(prs_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn(ts.btn_down), .level(lvl_down), .press(prs_down));

  state_t        state, state_next;
  logic [5:0]    hours_next, minutes_next, seconds_next;
  logic          commit_next, phase_clear;
  logic          ev_mode, ev_up, ev_down, step_up, step_down;
  logic          phase;
  logic [BW-1:0] blink_cnt;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                   : REPEAT_RATE_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          repeating, rep_held, rep_fire;

  // Only a lone held button repeats; holding both counts as no input.
  assign rep_held = (lvl_up ^ lvl_down) && (state != IDLE) && ts.enable;
  assign rep_fire = rep_held && (repeating ? (rep_cnt == RW'(REPEAT_RATE_CYCLES - 1))
                                           : (rep_cnt == RW'(REPEAT_DELAY_CYCLES - 1)));
  assign rep_up   = rep_fire & lvl_up;
  assign rep_down = rep_fire & lvl_down;
  assign unused_repeat = lvl_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (!rep_held) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      repeating <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
  assign unused_repeat = ^{lvl_mode, lvl_up, lvl_down,
                           32'(REPEAT_DELAY_CYCLES), 32'(REPEAT_RATE_CYCLES)};
`endif

  assign ev_mode   = prs_mode & ts.enable;
  assign ev_up     = (prs_up | rep_up) & ts.enable;
  assign ev_down   = (prs_down | rep_down) & ts.enable;
  assign step_up   = ev_up & ~ev_down & ~ev_mode;
  assign step_down = ev_down & ~ev_up & ~ev_mode;

  always_comb begin
    state_next   = state;
    hours_next   = ts.modified_hours;
    minutes_next = ts.modified_minutes;
    seconds_next = ts.modified_seconds;
    commit_next  = 1'b0;
    phase_clear  = 1'b0;
    case (state)
      IDLE: begin
        hours_next   = ts.cur_hours;
        minutes_next = ts.cur_minutes;
        seconds_next = ts.cur_seconds;
        if (ev_mode) begin
          state_next  = SET_HOUR;
          phase_clear = 1'b1;
        end
      end
      SET_HOUR: begin
        if (ev_mode) begin
          state_next  = SET_MIN;
          phase_clear = 1'b1;
        end else if (step_up || step_down) begin
          hours_next  = step_field(ts.modified_hours, HOUR_MAX, step_up);
          phase_clear = 1'b1;
        end
      end
      SET_MIN: begin
        if (ev_mode) begin
          state_next  = SET_SEC;
          phase_clear = 1'b1;
        end else if (step_up || step_down) begin
          minutes_next = step_field(ts.modified_minutes, MINSEC_MAX, step_up);
          phase_clear  = 1'b1;
        end
      end
      SET_SEC: begin
        if (ev_mode) begin
          state_next  = IDLE;
          commit_next = 1'b1;
        end else if (step_up || step_down) begin
          seconds_next = step_field(ts.modified_seconds, MINSEC_MAX, step_up);
          phase_clear  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort: drop back to live tracking without committing.
    if (!ts.enable) begin
      state_next   = IDLE;
      commit_next  = 1'b0;
      hours_next   = ts.cur_hours;
      minutes_next = ts.cur_minutes;
      seconds_next = ts.cur_seconds;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      ts.modified_hours   <= '0;
      ts.modified_minutes <= '0;
      ts.modified_seconds <= '0;
      ts.commit           <= 1'b0;
    end else begin
      state               <= state_next;
      ts.modified_hours   <= hours_next;
      ts.modified_minutes <= minutes_next;
      ts.modified_seconds <= seconds_next;
      ts.commit           <= commit_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 1'b0;
      blink_cnt <= '0;
    end else if (phase_clear || state_next == IDLE) begin
      phase     <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      phase     <= ~phase;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    ts.blink_mask = 6'b000000;
    if (phase) begin
      case (state)
        SET_HOUR: ts.blink_mask = BLINK_HOUR;
        SET_MIN:  ts.blink_mask = BLINK_MIN;
        SET_SEC:  ts.blink_mask = BLINK_SEC;
        default:  ts.blink_mask = 6'b000000;
      endcase
    end
  end

  assign ts.set_active = (state != IDLE);
endmodule
